// File: rtl/mem_rw_requester_if.sv
// ============================================================================
// mem_rw_requester_if : request/response channel plus memory helper port
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_rw_requester_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;

  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_write;
  logic              resp_err;

  logic              r_enable;
  logic [63:0]       r_index;
  logic [63:0]       r_data;
  logic              w_enable;
  logic [63:0]       w_index;
  logic [63:0]       w_data;
  logic [63:0]       w_mask;
  logic              mem_enable;

  // slave: the requester block itself; master: bus bridge plus memory model
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready, r_data,
    output req_ready, resp_valid, resp_rdata, resp_write, resp_err,
           r_enable, r_index, w_enable, w_index, w_data, w_mask, mem_enable
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready, r_data,
    input  req_ready, resp_valid, resp_rdata, resp_write, resp_err,
           r_enable, r_index, w_enable, w_index, w_data, w_mask, mem_enable
  );
endinterface

`default_nettype wire

// File: rtl/mem_rw_requester.sv
// ============================================================================
// mem_rw_requester : valid/ready byte-addressed requests to the word-indexed
// memory helper port, in-order responses via a credit-protected FIFO.
// Optional macro MEM_RW_REQUESTER_STATS_EN adds saturating access counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_rw_requester #(
  parameter int          ADDR_W         = 64,
  parameter logic [63:0] MEM_BASE       = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_SIZE_BYTES = 64'h0000_0002_0000_0000,
  parameter int          RESP_DEPTH     = 4
) (
  input  logic               clock,
  input  logic               reset,
  mem_rw_requester_if.slave  bus
`ifdef MEM_RW_REQUESTER_STATS_EN
  ,
  output logic [31:0]        stat_reads,
  output logic [31:0]        stat_writes,
  output logic [31:0]        stat_errs
`endif
);

  localparam int              PW      = $clog2(RESP_DEPTH);
  localparam logic [ADDR_W:0] BASE_X  = (ADDR_W+1)'(MEM_BASE);
  localparam logic [ADDR_W:0] SIZE_X  = (ADDR_W+1)'(MEM_SIZE_BYTES);
  localparam logic [PW+1:0]   DEPTH_C = (PW+2)'(RESP_DEPTH);

  // Extra top bit keeps the borrow of addr < base, so it always lands >= size
  logic [ADDR_W:0] offset;
  logic            addr_err;
  logic [63:0]     word_idx;
  logic [63:0]     strb_mask;
  logic            unused_low_bits;

  assign offset          = {1'b0, bus.req_addr} - BASE_X;
  assign addr_err        = (offset >= SIZE_X);
  assign word_idx        = 64'(offset[ADDR_W-1:3]);
  assign unused_low_bits = ^offset[2:0];

  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign strb_mask[8*i +: 8] = {8{bus.req_wstrb[i]}};
  end

  logic          s1_valid;
  logic          s1_write;
  logic          s1_err;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW+1:0] credit_used;
  logic          ready;
  logic          accept;
  logic          rd_fire;
  logic          wr_fire;

  // Credits cover the entry still in flight in s1, so the s1 push never overflows
  assign credit_used = (PW+2)'(count) + (PW+2)'(s1_valid);
  assign ready       = !reset && (credit_used < DEPTH_C);
  assign accept      = bus.req_valid && ready;
  assign rd_fire     = accept && !bus.req_write && !addr_err;
  assign wr_fire     = accept &&  bus.req_write && !addr_err && (bus.req_wstrb != 8'h00);

  assign bus.req_ready  = ready;
  assign bus.mem_enable = !reset;
  assign bus.r_enable   = rd_fire;
  assign bus.r_index    = rd_fire ? word_idx : 64'h0;
  assign bus.w_enable   = wr_fire;
  assign bus.w_index    = wr_fire ? word_idx : 64'h0;
  assign bus.w_data     = wr_fire ? bus.req_wdata : 64'h0;
  assign bus.w_mask     = wr_fire ? strb_mask : 64'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_write <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_write <= bus.req_write;
      s1_err   <= addr_err;
    end
  end

  logic [63:0] fifo_rdata [RESP_DEPTH];
  logic        fifo_write [RESP_DEPTH];
  logic        fifo_err   [RESP_DEPTH];
  logic        push;
  logic        pop;
  logic        resp_valid;
  logic [63:0] push_rdata;

  assign push       = s1_valid;
  assign push_rdata = (s1_write || s1_err) ? 64'h0 : bus.r_data;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid && bus.resp_ready;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= push_rdata;
      fifo_write[wr_ptr] <= s1_write;
      fifo_err[wr_ptr]   <= s1_err;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_valid ? fifo_rdata[rd_ptr] : 64'h0;
  assign bus.resp_write = resp_valid && fifo_write[rd_ptr];
  assign bus.resp_err   = resp_valid && fifo_err[rd_ptr];

`ifdef MEM_RW_REQUESTER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads  <= 32'h0;
      stat_writes <= 32'h0;
      stat_errs   <= 32'h0;
    end else begin
      if (accept && !bus.req_write && !addr_err && (stat_reads != 32'hFFFF_FFFF))
        stat_reads <= stat_reads + 32'h1;
      if (accept && bus.req_write && !addr_err && (stat_writes != 32'hFFFF_FFFF))
        stat_writes <= stat_writes + 32'h1;
      if (accept && addr_err && (stat_errs != 32'hFFFF_FFFF))
        stat_errs <= stat_errs + 32'h1;
    end
  end
`else
  // statistics counters are not built
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_rw_requester.sv
// ============================================================================
// tb_mem_rw_requester : scoreboard bench with a word memory model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_rw_requester;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SIZE  = 64'h0000_0002_0000_0000;
  localparam int          DEPTH = 4;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_rw_requester_if #(.ADDR_W(64)) bus ();

`ifdef MEM_RW_REQUESTER_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_errs;
`endif

  mem_rw_requester #(
    .ADDR_W(64), .MEM_BASE(BASE), .MEM_SIZE_BYTES(SIZE), .RESP_DEPTH(DEPTH)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
`ifdef MEM_RW_REQUESTER_STATS_EN
    ,
    .stat_reads(stat_reads),
    .stat_writes(stat_writes),
    .stat_errs(stat_errs)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic [63:0] ref_m [64];
  logic        cap_r_en, cap_w_en;
  logic [63:0] cap_r_idx, cap_w_idx, cap_w_mask, last_rdata;
  int          n_rd = 0, n_wr = 0, n_er = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [7:0] s);
    logic [63:0] m;
    m = 64'h0;
    for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Memory model: commits writes at the edge, returns read data one cycle later
  initial begin
    logic [63:0] mem_m [64];
    for (int i = 0; i < 64; i++) mem_m[i] = 64'h0;
    forever begin
      @(posedge clk);
      if (bus.w_enable)
        mem_m[bus.w_index[5:0]] = (mem_m[bus.w_index[5:0]] & ~bus.w_mask) | (bus.w_data & bus.w_mask);
      if (bus.r_enable)
        bus.r_data <= mem_m[bus.r_index[5:0]];
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [63:0] a, off, idx, m;
    logic        wr, err, er, ew;
    exp_t        e;
    for (int i = 0; i < 64; i++) ref_m[i] = 64'h0;
    forever begin
      @(negedge clk);
      check("mem_enable", bus.mem_enable, !rst);
      if (bus.req_valid && bus.req_ready) begin
        a   = bus.req_addr;
        wr  = bus.req_write;
        off = a - BASE;
        err = (a < BASE) || (off >= SIZE);
        idx = off >> 3;
        er  = !wr && !err;
        ew  = wr && !err && (bus.req_wstrb != 8'h00);
        m   = expand(bus.req_wstrb);
        check("r_enable", bus.r_enable, er);
        check("w_enable", bus.w_enable, ew);
        if (er) check("r_index", bus.r_index, idx);
        if (ew) begin
          check("w_index", bus.w_index, idx);
          check("w_data", bus.w_data, bus.req_wdata);
          check("w_mask", bus.w_mask, m);
        end
        cap_r_en = bus.r_enable;  cap_r_idx = bus.r_index;
        cap_w_en = bus.w_enable;  cap_w_idx = bus.w_index;  cap_w_mask = bus.w_mask;
        e.write = wr;
        e.err   = err;
        e.rdata = er ? ref_m[idx[5:0]] : 64'h0;
        if (ew) ref_m[idx[5:0]] = (ref_m[idx[5:0]] & ~m) | (bus.req_wdata & m);
        if (err) n_er++; else if (wr) n_wr++; else n_rd++;
        q.push_back(e);
      end else begin
        check("idle_strobes", {62'h0, bus.r_enable, bus.w_enable}, 64'h0);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_write", bus.resp_write, e.write);
          check("resp_err", bus.resp_err, e.err);
          last_rdata = bus.resp_rdata;
        end
      end
      if (rst) begin
        q.delete();
        n_rd = 0; n_wr = 0; n_er = 0;
      end
    end
  end

  task automatic send(input logic wr, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 50);
    if (!bus.req_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || bus.resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   k;
    logic took;
    logic [2:0] sel;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 64'h0;
    bus.req_wdata  = 64'h0;
    bus.req_wstrb  = 8'h0;
    bus.resp_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_resp_valid", bus.resp_valid, 0);
    @(posedge clk); #1;

    // Write then read of the same word on the next cycle
    send(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'h0F);
    check("wr_index", cap_w_idx, 64'd2);
    check("wr_mask", cap_w_mask, 64'h0000_0000_FFFF_FFFF);
    send(1'b0, 64'h8000_0010, 64'h0, 8'h0);
    check("rd_index", cap_r_idx, 64'd2);
    wait_drain();
    check("rd_after_wr", last_rdata, 64'h0000_0000_5566_7788);

    // Accept-to-response latency of two cycles
    send(1'b0, 64'h8000_0010, 64'h0, 8'h0);
    @(negedge clk);
    check("lat_a1_valid", bus.resp_valid, 0);
    @(negedge clk);
    check("lat_a2_valid", bus.resp_valid, 1);
    wait_drain();

    // Range boundaries and zero-strobe write
    send(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h0);
    check("below_base_ren", cap_r_en, 0);
    send(1'b0, 64'h2_8000_0000, 64'h0, 8'h0);
    check("past_end_ren", cap_r_en, 0);
    send(1'b0, 64'h2_7FFF_FFFF, 64'h0, 8'h0);
    check("last_word_ren", cap_r_en, 1);
    check("last_word_idx", cap_r_idx, 64'h3FFF_FFFF);
    send(1'b1, 64'h0, 64'hDEAD, 8'hFF);
    check("err_wen", cap_w_en, 0);
    send(1'b1, 64'h8000_0018, 64'hBEEF, 8'h00);
    check("zero_strb_wen", cap_w_en, 0);
    wait_drain();

    for (int w = 8; w < 16; w++) send(1'b1, BASE + 64'(8 * w), {$urandom, $urandom}, 8'hFF);
    send(1'b1, BASE + 64'(8 * 9), 64'h0123_4567_89AB_CDEF, 8'hA5);
    wait_drain();

    // Back-pressure: only DEPTH reads may be accepted
    bus.resp_ready = 1'b0;
    k = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = BASE + 64'(8 * 8);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.req_ready) k++;
      @(posedge clk); #1;
      bus.req_addr = BASE + 64'(8 * (8 + k));
    end
    bus.req_valid = 1'b0;
    check("bp_accepted", k, DEPTH);
    @(negedge clk);
    check("bp_ready_low", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before_pop", bus.req_ready, 0);
    @(negedge clk);
    check("bp_ready_after_pop", bus.req_ready, 1);
    wait_drain();

    // Reset with two entries queued and one in flight
    bus.resp_ready = 1'b0;
    send(1'b0, BASE + 64'(8 * 8), 64'h0, 8'h0);
    send(1'b0, BASE + 64'(8 * 9), 64'h0, 8'h0);
    send(1'b0, BASE + 64'(8 * 10), 64'h0, 8'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_mid_rst_valid", bus.resp_valid, 0);
    end
    @(posedge clk); #1;
    send(1'b0, BASE + 64'(8 * 9), 64'h0, 8'h0);
    wait_drain();

    // Random traffic with random response back-pressure
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      took = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      bus.resp_ready = ($urandom_range(3) != 0);
      if (took || !bus.req_valid) begin
        bus.req_valid = ($urandom_range(3) != 0);
        bus.req_write = $urandom_range(1) == 1;
        bus.req_wdata = {$urandom, $urandom};
        bus.req_wstrb = 8'($urandom);
        sel = 3'($urandom_range(7));
        case (sel)
          3'd0:    bus.req_addr = 64'h7FFF_FFF8 + 64'($urandom_range(7));
          3'd1:    bus.req_addr = 64'h2_8000_0000 + 64'($urandom_range(7));
          3'd2:    bus.req_addr = 64'h2_7FFF_FFF8 + 64'($urandom_range(7));
          default: bus.req_addr = BASE + 64'(8 * $urandom_range(15)) + 64'($urandom_range(7));
        endcase
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    wait_drain();

`ifdef MEM_RW_REQUESTER_STATS_EN
    check("stat_reads", stat_reads, n_rd);
    check("stat_writes", stat_writes, n_wr);
    check("stat_errs", stat_errs, n_er);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
